// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage
package fetch_pkg;
    localparam int INSTR_BYTES = 4;
    typedef enum logic {IDLE, WAIT} fetch_state_t;
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fq_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: first-word fall-through FIFO of fetched {pc, instr} entries with flush
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int LOG_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 flush,
    input  fq_entry_t            push_data,
    output fq_entry_t            head,
    output logic [LOG_DEPTH:0]   count
);
    localparam int DEPTH = 1 << LOG_DEPTH;
    fq_entry_t mem [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign do_pop  = pop & (count != '0);
    assign do_push = push & (count != (LOG_DEPTH+1)'(DEPTH));
    // Empty queue presents zeros so decode never sees stale storage.
    assign head = (count != '0) ? mem[rd_ptr] : '0;
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + LOG_DEPTH'(do_push);
            rd_ptr <= rd_ptr + LOG_DEPTH'(do_pop);
            count  <= count + (LOG_DEPTH+1)'(do_push) - (LOG_DEPTH+1)'(do_pop);
        end
    end
    always_ff @(posedge clk)
        if (do_push && !flush && !reset) mem[wr_ptr] <= push_data;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: holds the PC, issues one I-cache request at a time and queues
// returned instructions for decode; redirects flush the queue and drop stale data.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH         = 64,
    parameter int                    LOG_WORDS_PER_LINE = 4,
    parameter int                    LINE_ADDR_WIDTH    = 58,
    parameter int                    WORD_SIZE          = 4,
    parameter int                    LOG_FQ_DEPTH       = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC           = 64'h0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fetch_en,
    input  logic                       redirect_valid,
    input  logic [ADDR_WIDTH-1:0]      redirect_pc,
    output logic                       proc_req,
    output logic [LINE_ADDR_WIDTH-1:0] proc_line_addr,
    output logic [LOG_WORDS_PER_LINE-1:0] proc_word_select,
    input  logic                       proc_ack,
    input  logic [31:0]                proc_data_out,
    output logic                       dec_valid,
    output logic [31:0]                dec_instr,
    output logic [ADDR_WIDTH-1:0]      dec_pc,
    input  logic                       dec_ready
);
    localparam int BYTE_BITS = $clog2(WORD_SIZE);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(INSTR_BYTES - 1);
    fetch_state_t state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d, pend_q, pend_d, redir_pc;
    logic stale_q, stale_d, push, has_room;
    logic [LOG_FQ_DEPTH:0] count;
    fq_entry_t head;
    assign redir_pc         = redirect_pc & ALIGN_MASK;
    assign proc_line_addr   = pc_q[ADDR_WIDTH-1 -: LINE_ADDR_WIDTH];
    assign proc_word_select = pc_q[BYTE_BITS +: LOG_WORDS_PER_LINE];
    assign has_room         = count < (LOG_FQ_DEPTH+1)'(1 << LOG_FQ_DEPTH);
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC & ALIGN_MASK;
            pend_q  <= '0;
            stale_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            stale_q <= stale_d;
        end
    end
    // pc_q only moves in IDLE or on the ack edge, so the cache sees a stable address while waiting.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pend_d   = pend_q;
        stale_d  = stale_q;
        push     = 1'b0;
        proc_req = 1'b0;
        if (state_q == IDLE) begin
            pc_d    = redirect_valid ? redir_pc : pc_q;
            state_d = (fetch_en && has_room && !redirect_valid) ? WAIT : IDLE;
        end else begin
            proc_req = ~proc_ack;
            if (proc_ack) begin
                state_d = IDLE;
                stale_d = 1'b0;
                pc_d    = redirect_valid ? redir_pc : stale_q ? pend_q : pc_q + ADDR_WIDTH'(WORD_SIZE);
                push    = ~redirect_valid & ~stale_q;
            end else if (redirect_valid) begin
                pend_d  = redir_pc;
                stale_d = 1'b1;
            end
        end
    end
    fetch_queue #(.LOG_DEPTH(LOG_FQ_DEPTH)) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (dec_ready),
        .flush     (redirect_valid),
        .push_data ('{pc: 64'(pc_q), instr: proc_data_out}),
        .head      (head),
        .count     (count)
    );
    assign dec_valid = count != '0;
    assign dec_instr = head.instr;
    assign dec_pc    = head.pc[ADDR_WIDTH-1:0];
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios for fetch_unit with a hand-driven I-cache responder
module tb_fetch_unit;
    logic clk = 0, reset = 1, fetch_en = 0, redirect_valid = 0, proc_ack = 0, dec_ready = 0;
    logic [63:0] redirect_pc = '0;
    logic [31:0] proc_data_out = '0;
    logic proc_req, dec_valid;
    logic [57:0] proc_line_addr;
    logic [3:0] proc_word_select;
    logic [31:0] dec_instr;
    logic [63:0] dec_pc;
    logic [63:0] pc;
    int checks = 0, failures = 0;

    fetch_unit #(.RESET_PC(64'h1000)) dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .proc_req(proc_req), .proc_line_addr(proc_line_addr),
        .proc_word_select(proc_word_select), .proc_ack(proc_ack), .proc_data_out(proc_data_out),
        .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_ready(dec_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] req_pc();
        return {proc_line_addr, proc_word_select, 2'b00};
    endfunction

    task automatic wait_req(output logic [63:0] seen);
        int n = 0;
        while (!proc_req && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (proc_req !== 1'b1) begin failures++; $display("FAIL req_timeout: proc_req=%b after %0d cycles, required 1", proc_req, n); end
        seen = req_pc();
    endtask

    task automatic serve(input logic [31:0] d);
        repeat (2) @(negedge clk);
        proc_ack = 1; proc_data_out = d;
        @(negedge clk);
        proc_ack = 0;
    endtask

    task automatic do_reset();
        reset = 1; proc_ack = 0; redirect_valid = 0; fetch_en = 0;
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (2) @(negedge clk);
        checks++; if (proc_req !== 1'b0) begin failures++; $display("FAIL rst_req: got %b expected 0", proc_req); end
        checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b expected 0", dec_valid); end
        checks++; if (dec_instr !== 32'h0) begin failures++; $display("FAIL rst_instr: got %h expected 0", dec_instr); end
        checks++; if (dec_pc !== 64'h0) begin failures++; $display("FAIL rst_dec_pc: got %h expected 0", dec_pc); end
        checks++; if (req_pc() !== 64'h1000) begin failures++; $display("FAIL rst_pc: got %h expected 1000", req_pc()); end
        reset = 0;
    endtask

    task automatic test_first_fetch();
        dec_ready = 1; fetch_en = 1;
        wait_req(pc);
        checks++; if (proc_line_addr !== 58'h40) begin failures++; $display("FAIL first_line: got %h expected 40", proc_line_addr); end
        checks++; if (proc_word_select !== 4'd0) begin failures++; $display("FAIL first_word: got %h expected 0", proc_word_select); end
        repeat (2) @(negedge clk);
        proc_ack = 1; proc_data_out = 32'h13;
        #1;
        checks++; if (proc_req !== 1'b0) begin failures++; $display("FAIL req_in_ack: got %b expected 0", proc_req); end
        @(negedge clk);
        proc_ack = 0;
        checks++; if (dec_valid !== 1'b1) begin failures++; $display("FAIL first_valid: got %b expected 1", dec_valid); end
        checks++; if (dec_pc !== 64'h1000) begin failures++; $display("FAIL first_dec_pc: got %h expected 1000", dec_pc); end
        checks++; if (dec_instr !== 32'h13) begin failures++; $display("FAIL first_instr: got %h expected 13", dec_instr); end
        checks++; if (proc_req !== 1'b0) begin failures++; $display("FAIL gap_req: got %b expected 0", proc_req); end
        @(negedge clk);
        checks++; if (proc_req !== 1'b1) begin failures++; $display("FAIL second_req: got %b expected 1", proc_req); end
        checks++; if (proc_word_select !== 4'd1) begin failures++; $display("FAIL second_word: got %h expected 1", proc_word_select); end
        checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL popped_valid: got %b expected 0", dec_valid); end
    endtask

    task automatic test_queue_full();
        do_reset();
        dec_ready = 0; fetch_en = 1;
        for (int i = 0; i < 4; i++) begin
            wait_req(pc);
            checks++; if (pc !== 64'h1000 + 64'(4 * i)) begin failures++; $display("FAIL fill_pc%0d: got %h expected %h", i, pc, 64'h1000 + 64'(4 * i)); end
            serve(32'hA0 + 32'(i));
        end
        checks++; if (dec_pc !== 64'h1000) begin failures++; $display("FAIL full_head_pc: got %h expected 1000", dec_pc); end
        checks++; if (dec_instr !== 32'hA0) begin failures++; $display("FAIL full_head_instr: got %h expected a0", dec_instr); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (proc_req !== 1'b0) begin failures++; $display("FAIL full_req%0d: got %b expected 0", i, proc_req); end
        end
        dec_ready = 1;
        @(negedge clk);
        dec_ready = 0;
        checks++; if (dec_pc !== 64'h1004) begin failures++; $display("FAIL pop_pc: got %h expected 1004", dec_pc); end
        checks++; if (dec_instr !== 32'hA1) begin failures++; $display("FAIL pop_instr: got %h expected a1", dec_instr); end
        wait_req(pc);
        checks++; if (pc !== 64'h1010) begin failures++; $display("FAIL after_pop_pc: got %h expected 1010", pc); end
    endtask

    task automatic test_line_cross();
        do_reset();
        dec_ready = 1; fetch_en = 1; redirect_valid = 1; redirect_pc = 64'h1038;
        @(negedge clk);
        redirect_valid = 0;
        checks++; if (proc_req !== 1'b0) begin failures++; $display("FAIL redir_idle_req: got %b expected 0", proc_req); end
        checks++; if (req_pc() !== 64'h1038) begin failures++; $display("FAIL redir_idle_pc: got %h expected 1038", req_pc()); end
        wait_req(pc);
        serve(32'h1);
        wait_req(pc);
        checks++; if (proc_word_select !== 4'd15 || proc_line_addr !== 58'h40) begin failures++; $display("FAIL last_word: got %h/%h expected 40/f", proc_line_addr, proc_word_select); end
        serve(32'h2);
        wait_req(pc);
        checks++; if (proc_line_addr !== 58'h41) begin failures++; $display("FAIL cross_line: got %h expected 41", proc_line_addr); end
        checks++; if (proc_word_select !== 4'd0) begin failures++; $display("FAIL cross_word: got %h expected 0", proc_word_select); end
    endtask

    task automatic test_wrap();
        do_reset();
        dec_ready = 1; fetch_en = 1; redirect_valid = 1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
        @(negedge clk);
        redirect_valid = 0;
        wait_req(pc);
        checks++; if (pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin failures++; $display("FAIL wrap_start: got %h expected fffffffffffffffc", pc); end
        serve(32'h99);
        checks++; if (dec_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin failures++; $display("FAIL wrap_dec_pc: got %h expected fffffffffffffffc", dec_pc); end
        wait_req(pc);
        checks++; if (pc !== 64'h0) begin failures++; $display("FAIL wrap_next: got %h expected 0", pc); end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        dec_ready = 0; fetch_en = 1;
        wait_req(pc); serve(32'h1);
        wait_req(pc); serve(32'h2);
        wait_req(pc);
        checks++; if (pc !== 64'h1008) begin failures++; $display("FAIL rw_pc: got %h expected 1008", pc); end
        checks++; if (dec_valid !== 1'b1) begin failures++; $display("FAIL rw_queued: got %b expected 1", dec_valid); end
        redirect_valid = 1; redirect_pc = 64'h2002;
        @(negedge clk);
        redirect_valid = 0;
        checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL rw_flush: got %b expected 0", dec_valid); end
        checks++; if (proc_req !== 1'b1) begin failures++; $display("FAIL rw_req_held: got %b expected 1", proc_req); end
        @(negedge clk);
        checks++; if (req_pc() !== 64'h1008) begin failures++; $display("FAIL rw_addr_stable: got %h expected 1008", req_pc()); end
        proc_ack = 1; proc_data_out = 32'hDEAD;
        @(negedge clk);
        proc_ack = 0;
        checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL rw_stale_drop: got %b expected 0", dec_valid); end
        wait_req(pc);
        checks++; if (proc_line_addr !== 58'h80 || proc_word_select !== 4'd0) begin failures++; $display("FAIL rw_target: got %h/%h expected 80/0", proc_line_addr, proc_word_select); end
        serve(32'h55);
        checks++; if (dec_pc !== 64'h2000) begin failures++; $display("FAIL rw_dec_pc: got %h expected 2000", dec_pc); end
        checks++; if (dec_instr !== 32'h55) begin failures++; $display("FAIL rw_dec_instr: got %h expected 55", dec_instr); end
    endtask

    task automatic test_redirect_ack();
        wait_req(pc);
        repeat (2) @(negedge clk);
        proc_ack = 1; proc_data_out = 32'hBAD; redirect_valid = 1; redirect_pc = 64'h3000;
        @(negedge clk);
        proc_ack = 0; redirect_valid = 0;
        checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL ra_flush: got %b expected 0", dec_valid); end
        checks++; if (proc_req !== 1'b0) begin failures++; $display("FAIL ra_req: got %b expected 0", proc_req); end
        wait_req(pc);
        checks++; if (pc !== 64'h3000) begin failures++; $display("FAIL ra_pc: got %h expected 3000", pc); end
    endtask

    task automatic test_double_redirect();
        redirect_valid = 1; redirect_pc = 64'h4000;
        @(negedge clk);
        redirect_pc = 64'h5004;
        @(negedge clk);
        redirect_valid = 0;
        checks++; if (req_pc() !== 64'h3000) begin failures++; $display("FAIL dr_stable: got %h expected 3000", req_pc()); end
        fetch_en = 0; proc_ack = 1; proc_data_out = 32'h66;
        @(negedge clk);
        proc_ack = 0;
        checks++; if (req_pc() !== 64'h5004) begin failures++; $display("FAIL dr_pending: got %h expected 5004", req_pc()); end
        checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL dr_drop: got %b expected 0", dec_valid); end
        proc_ack = 1; proc_data_out = 32'h77;
        @(negedge clk);
        proc_ack = 0;
        checks++; if (dec_valid !== 1'b0 || proc_req !== 1'b0) begin failures++; $display("FAIL spurious_ack: valid=%b req=%b expected 0/0", dec_valid, proc_req); end
        checks++; if (req_pc() !== 64'h5004) begin failures++; $display("FAIL spurious_pc: got %h expected 5004", req_pc()); end
        fetch_en = 1;
        wait_req(pc);
        checks++; if (proc_line_addr !== 58'h140 || proc_word_select !== 4'd1) begin failures++; $display("FAIL dr_req: got %h/%h expected 140/1", proc_line_addr, proc_word_select); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        dec_ready = 0; fetch_en = 1;
        for (int i = 0; i < 3; i++) begin wait_req(pc); serve(32'hC0 + 32'(i)); end
        wait_req(pc);
        checks++; if (pc !== 64'h100C) begin failures++; $display("FAIL rm_pc: got %h expected 100c", pc); end
        reset = 1;
        @(negedge clk);
        checks++; if (proc_req !== 1'b0 || dec_valid !== 1'b0) begin failures++; $display("FAIL rm_clear: req=%b valid=%b expected 0/0", proc_req, dec_valid); end
        reset = 0;
        wait_req(pc);
        checks++; if (pc !== 64'h1000) begin failures++; $display("FAIL rm_restart: got %h expected 1000", pc); end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_queue_full();
        test_line_cross();
        test_wrap();
        test_redirect_wait();
        test_redirect_ack();
        test_double_redirect();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the direct-mapped instruction cache.
- Holds the PC and issues one cache request at a time: line address plus word select.
- Captures each returned 32-bit instruction with its PC into a small queue that feeds decode.
- Handles redirects from execute by dropping stale responses and flushing the queue.

Parameters:
- ADDR_WIDTH, 64, PC width in bits.
- LOG_WORDS_PER_LINE, 4, log2 of 32-bit words per cache line (64-byte lines).
- LINE_ADDR_WIDTH, 58, cache line-address width (ADDR_WIDTH-6).
- WORD_SIZE, 4, bytes per instruction.
- LOG_FQ_DEPTH, 2, log2 of fetch-queue depth (FQ_DEPTH = 4).
- RESET_PC, 64'h0, PC loaded on reset.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- fetch_en  input  1  permits new cache requests; an in-flight request always completes
- redirect_valid  input  1  single-cycle redirect pulse from execute
- redirect_pc  input  64  redirect target; bits [1:0] ignored
- proc_req  output  1  request to the I-cache
- proc_line_addr  output  58  PC[63:6]
- proc_word_select  output  4  PC[5:2]
- proc_ack  input  1  one-cycle acknowledge from the I-cache
- proc_data_out  input  32  instruction, valid when proc_ack=1
- dec_valid  output  1  queue head valid
- dec_instr  output  32  queue head instruction
- dec_pc  output  64  queue head PC
- dec_ready  input  1  decode consumes the head this cycle

Behaviour:
- Reset (synchronous, active-high, clk rising edge), as seen after the edge:
  - pc_q = RESET_PC with [1:0] = 0; state = IDLE.
  - Queue empty; stale flag = 0.
  - proc_req = 0; dec_valid = 0; dec_instr = 0; dec_pc = 0.
- proc_line_addr and proc_word_select are driven from pc_q at all times.
- Address stability: pc_q must not change while state = WAIT. The cache reads the address throughout its miss sequence.
- States:
  - IDLE: go to WAIT when fetch_en = 1, queue count < FQ_DEPTH, and no redirect this cycle.
  - WAIT: proc_req is held. On proc_ack, return to IDLE.
- proc_req = (state == WAIT) & ~proc_ack. It is forced low combinationally during the ack cycle so the cache, back in idle, does not restart on the old address. This gives a minimum of one cycle between the ack and the next request.
- Normal ack in WAIT (stale = 0):
  - Push {pc_q, proc_data_out} into the queue.
  - pc_q += 4, modulo 2^64; wrap-around is allowed.
  - Crossing a line boundary simply increments proc_line_addr.
- Queue fullness: a request is issued only when count < FQ_DEPTH. With one outstanding request and pushes only on ack, the push always fits, so there is no overflow path.
- Redirect in IDLE:
  - pc_q = {redirect_pc[63:2], 2'b00}.
  - Queue flushed to count = 0.
  - No request in the redirect cycle.
- Redirect in WAIT without ack:
  - pc_q is not updated (address stability).
  - redirect_pc is latched into a pending register; stale = 1; queue flushed.
- Ack while stale = 1:
  - Data is dropped.
  - pc_q = pending target; stale = 0; go to IDLE.
- Redirect in the same cycle as ack:
  - Data is dropped and the queue is flushed.
  - pc_q = the new redirect_pc, which takes priority over a pending target; stale = 0.
- A second redirect while stale = 1 overwrites the pending target.
- Spurious proc_ack in IDLE is ignored.
- Queue behaviour:
  - First-word fall-through: dec_valid = (count != 0); dec_instr and dec_pc come from the head.
  - Pop when dec_valid & dec_ready.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - Pop when empty is ignored.
  - A flush overrides a push or pop in the same cycle.
  - Pointers wrap modulo FQ_DEPTH.
- Latency: a cache hit gives PC issue → dec_valid in 3 cycles (request, tag compare, registered ack → push visible the next cycle). Steady-state hit throughput is one instruction per 3 cycles.
- Reset mid-request abandons the request. The cache shares the same reset.

Decomposition:
- fetch_pkg:
  - fetch_state_t enum {IDLE, WAIT}
  - fq_entry_t struct {logic [63:0] pc; logic [31:0] instr}
  - constant INSTR_BYTES = 4
- Sub-module fetch_queue: parameterised sync FIFO of fq_entry_t with push, pop, flush, count, head outputs.

Test Plan:
- Reset with RESET_PC=64'h1000, fetch_en=1; cache acks 0x00000013 two cycles after req → first req has proc_line_addr=0x40, word_select=0. Next cycle: dec_valid=1, dec_pc=0x1000, dec_instr=0x13. Next req has word_select=1 (PC 0x1004), with proc_req low during the ack cycle.
- dec_ready=0, every request acked → exactly 4 entries queued (0x1000–0x100C), proc_req stays 0. Raise dec_ready for one cycle → one pop, next req at PC 0x1010.
- PC 0x103C acked → next req line 0x41, word_select 0 (PC 0x1040).
- Redirect to 0x2002 while WAIT on PC 0x1008 with 2 queued → queue empty next cycle, proc_line_addr unchanged until ack. Ack data not queued; next req line 0x80, word 0, dec_pc 0x2000.
- Redirect to 0x3000 in the same cycle as ack → ack data dropped, queue empty, next req PC 0x3000.
- Reset asserted while WAIT with 3 queued → next cycle proc_req=0, dec_valid=0, and the next request uses RESET_PC.
